// File: rtl/fod_mmd_divider.sv
// Multi-modulus divider for the FOD loop: divides CLK by a per-period ratio,
// emits a period-start strobe and re-times the DTC code onto period boundaries.
module fod_mmd_divider #(
    parameter int DCW_W   = 6,
    parameter int DTC_W   = 10,
    parameter int DIV_MIN = 4,
    parameter int DIV_MAX = 63,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             NRST,
    input  logic             EN,
    input  logic [DCW_W-1:0] MMD_DCW,
    input  logic [DTC_W-1:0] DTC_DCW,
    output logic             DIV_CLK,
    output logic             DIV_PULSE,
    output logic [DTC_W-1:0] DTC_CODE,
    output logic             CLAMP_ERR,
    output logic [CNT_W-1:0] PERIOD_CNT,
    output logic             BUSY
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [DCW_W-1:0] MIN_V = DCW_W'(DIV_MIN);
    localparam logic [DCW_W-1:0] MAX_V = DCW_W'(DIV_MAX);
    localparam logic [DCW_W-1:0] ONE_V = DCW_W'(1);

    state_t             r_state;
    logic [DCW_W-1:0]   r_cnt;
    logic [DCW_W-1:0]   r_n_cur;
    logic               r_div_clk;
    logic               r_div_pulse;
    logic [DTC_W-1:0]   r_dtc_code;
    logic               r_clamp_err;
    logic [CNT_W-1:0]   r_period_cnt;

    logic               w_load;
    logic               w_stop;
    logic               w_under;
    logic               w_over;
    logic [DCW_W-1:0]   w_ratio;
    logic [DCW_W-1:0]   w_cnt_next;
    logic [DCW_W-1:0]   w_n_next;
    logic               w_div_clk_next;

    always_comb begin
        w_load     = EN && ((r_state == S_IDLE) || (r_cnt == ONE_V));
        w_stop     = (r_state == S_RUN) && (r_cnt == ONE_V) && !EN;
        w_under    = MMD_DCW < MIN_V;
        w_over     = MMD_DCW > MAX_V;
        w_ratio    = w_under ? MIN_V : (w_over ? MAX_V : MMD_DCW);
        w_cnt_next = r_cnt;
        w_n_next   = r_n_cur;
        if (w_load) begin
            w_cnt_next = w_ratio;
            w_n_next   = w_ratio;
        end else if (w_stop) begin
            w_cnt_next = '0;
        end else if ((r_state == S_RUN) && (r_cnt > ONE_V)) begin
            w_cnt_next = r_cnt - ONE_V;
        end
        // High while the remaining count is in the upper half: ceil(N/2) high cycles.
        w_div_clk_next = w_cnt_next > (w_n_next >> 1);
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_n_cur      <= '0;
            r_div_clk    <= 1'b0;
            r_div_pulse  <= 1'b0;
            r_dtc_code   <= '0;
            r_clamp_err  <= 1'b0;
            r_period_cnt <= '0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_n_cur     <= w_n_next;
            r_div_clk   <= w_div_clk_next;
            r_div_pulse <= w_load;
            if (w_load) begin
                r_state      <= S_RUN;
                r_dtc_code   <= DTC_DCW;
                r_period_cnt <= r_period_cnt + 1'b1;
                if (w_under || w_over) begin
                    r_clamp_err <= 1'b1;
                end
            end else if (w_stop) begin
                r_state     <= S_IDLE;
                r_clamp_err <= 1'b0;
            end
        end
    end

    assign DIV_CLK    = r_div_clk;
    assign DIV_PULSE  = r_div_pulse;
    assign DTC_CODE   = r_dtc_code;
    assign CLAMP_ERR  = r_clamp_err;
    assign PERIOD_CNT = r_period_cnt;
    assign BUSY       = (r_state == S_RUN);

endmodule

// File: doc/fod_mmd_divider.md
# fod_mmd_divider

Cycle-accurate digital model and control front end of the FOD multi-modulus divider. It runs on the PLL output clock and divides it by the per-period ratio `MMD_DCW` coming from the FOD controller. It produces the divided clock that serves as the controller's `CLK`, plus a one-cycle period-start strobe. It also re-times the controller's `DTC_DCW` so the DTC code changes exactly at a divided-clock period boundary.

## Interface
Parameters:
- `DCW_W`, 6: width of `MMD_DCW`.
- `DTC_W`, 10: width of the DTC code path.
- `DIV_MIN`, 4: minimum legal divide ratio.
- `DIV_MAX`, 63: maximum legal divide ratio; must satisfy `DIV_MAX` ≤ 2^`DCW_W`−1.
- `CNT_W`, 16: width of the period counter.

Ports:
- `CLK` input 1: PLL output clock (undivided).
- `NRST` input 1: reset, asynchronous, active-low.
- `EN` input 1: divider run request.
- `MMD_DCW` input `DCW_W`: divide ratio for the next period, unsigned.
- `DTC_DCW` input `DTC_W`: DTC code for the next period.
- `DIV_CLK` output 1: divided clock, registered.
- `DIV_PULSE` output 1: high during the first `CLK` cycle of each divided period.
- `DTC_CODE` output `DTC_W`: re-timed DTC code.
- `CLAMP_ERR` output 1: sticky flag, set when an out-of-range ratio was clamped.
- `PERIOD_CNT` output `CNT_W`: count of divided periods started, wraps.
- `BUSY` output 1: high in state RUN.

## Operation
- **States.**
  - IDLE: `cnt`=0.
  - RUN: `cnt` counts down from N to 1.
- **Load event**, in a cycle where (IDLE & `EN`) or (RUN & `cnt`==1 & `EN`). At the following edge:
  - `MMD_DCW` is sampled, clamped to [`DIV_MIN`, `DIV_MAX`], and written to `n_cur` and `cnt`.
  - `DTC_DCW` is written to `DTC_CODE`.
  - `PERIOD_CNT` increments.
  - `DIV_PULSE` goes to 1.
- **Non-load cycles in RUN, `cnt`>1:** `cnt` decrements. `DIV_PULSE` goes to 0. `n_cur` and `DTC_CODE` hold.
- **Graceful stop:** in RUN with `cnt`==1 and `EN`=0, the next state is IDLE, with `cnt`=0 and `DIV_CLK`=0. `EN` falling mid-period never truncates the current period.
- **`EN` low in IDLE:** all outputs hold. `DTC_CODE` and `PERIOD_CNT` keep their last values.
- **Duty cycle:** `DIV_CLK` is registered from next-state values as (`cnt_next` > (`n_next`>>1)). It is high for the first ceil(N/2) cycles and low for the last floor(N/2) cycles of each period.
  - N=4 gives 2 high / 2 low.
  - N=5 gives 3 high / 2 low.
- **Clamp:** a sampled ratio below `DIV_MIN` becomes `DIV_MIN`; above `DIV_MAX` becomes `DIV_MAX`. Either case sets `CLAMP_ERR`.
  - `CLAMP_ERR` clears only on reset or on the transition into IDLE.
- **Period counter:** `PERIOD_CNT` wraps from 2^`CNT_W`−1 to 0 with no flag.
- **`BUSY`:** high exactly when the state is RUN.
- **Reset** (at any time, including mid-period): asynchronous return to IDLE. All outputs are 0: `DIV_CLK`, `DIV_PULSE`, `DTC_CODE`, `CLAMP_ERR`, `PERIOD_CNT`, `BUSY`, and internal `cnt` / `n_cur`.

## Timing
- Start latency: `EN` sampled high in IDLE at edge k gives `DIV_PULSE`=1, `DIV_CLK`=1 and `BUSY`=1 in the cycle after edge k.
- Divided period = `n_cur` `CLK` cycles exactly; periods are back-to-back with no gap while `EN`=1.
- Ratio and code update point: `MMD_DCW` and `DTC_DCW` are sampled only at load edges. The values present during the last cycle of a period (`cnt`==1) define the next period. Changes at other times are ignored.
- `DTC_CODE` changes only on the same edge where `DIV_PULSE` rises, i.e. aligned to the `DIV_CLK` rising edge.
- All outputs are glitch-free flops clocked by `CLK`; there are no combinational paths from inputs to outputs.
- Stop latency: once `EN` falls, `BUSY` deasserts on the edge after the current period's `cnt`==1 cycle.
- `EN` toggling for a single cycle in RUN with `cnt`>1 has no effect.

## Test plan
- **Constant ratio:** `EN`=1, `MMD_DCW`=4 → `DIV_PULSE` every 4 cycles, `DIV_CLK` pattern 1100 repeating, `PERIOD_CNT` +1 per period, `CLAMP_ERR`=0.
- **Ratio change:** `MMD_DCW` switches 4→7 in the middle of a period → the current period stays 4 cycles, the next is 7 cycles with `DIV_CLK` 1111000. `DTC_DCW` changed at the same time to 0x155 → `DTC_CODE`=0x155 only from the next `DIV_PULSE`.
- **Clamp:** `MMD_DCW`=2 → period is 4 cycles and `CLAMP_ERR`=1. It stays 1 after `MMD_DCW`=10 and clears only after `EN`=0 drives the state to IDLE.
- **Graceful stop:** `MMD_DCW`=9, `EN` drops at `cnt`=6 → the period completes all 9 cycles. `BUSY`=0 and `DIV_CLK`=0 afterwards; `DTC_CODE` and `PERIOD_CNT` hold.
- **Reset mid-period:** assert `NRST`=0 at `cnt`=3 of an N=8 period → all outputs 0 immediately. After release with `EN`=1, the first `DIV_PULSE` arrives one cycle after the first sampling edge.
- **Wrap:** run 65536 periods of N=4 → `PERIOD_CNT` returns to 0 with the output cadence undisturbed.
